// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared defaults and types for the window sequencer
// Purpose: default geometry of the capture ring buffer, the sequencer state
//          encoding and the segment index type.
// Ports:   none (package).
package sampler_pkg;

  localparam int DEFAULT_ADDR_W      = 13;
  localparam int DEFAULT_SEG_W       = 3;
  localparam int DEFAULT_WINDOW_SEGS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef logic [DEFAULT_SEG_W-1:0] seg_idx_t;

endpackage

// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - ring-buffer write pointer and analysis window scheduler
// Purpose: owns the ring-buffer write pointer, counts completed segments and
//          issues one go pulse per completed segment once a full window is
//          resident, with one-outstanding-window flow control.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   enable          - run/stop; low forces IDLE
//   sample_valid    - a captured sample is presented this cycle
//   ring_buf_addr   - registered write pointer
//   ring_buf_wren   - write strobe (sample_valid outside IDLE)
//   window_start    - oldest segment of the issued window, valid with go_out
//   go_out          - single-cycle start pulse to the hannifier
//   hann_done       - hannifier finished the current window
//   overrun         - sticky dropped-window flag
//   overrun_clr     - clears overrun
//   drop_count      - saturating dropped-window count (WINDOW_SEQUENCER_DROP_COUNT_EN only)
// Option: define WINDOW_SEQUENCER_DROP_COUNT_EN to add drop_count.
module window_sequencer
  import sampler_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SEG_W       = DEFAULT_SEG_W,
  parameter int WINDOW_SEGS = DEFAULT_WINDOW_SEGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  output logic [ADDR_W-1:0] ring_buf_addr,
  output logic              ring_buf_wren,
  output logic [SEG_W-1:0]  window_start,
  output logic              go_out,
  input  logic              hann_done,
  output logic              overrun,
  input  logic              overrun_clr
`ifdef WINDOW_SEQUENCER_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int OFF_W = ADDR_W - SEG_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
  logic [SEG_W-1:0]  ws_q, ws_d;
  logic              in_flight_q, in_flight_d;
  logic              go_q, go_d;
  logic              overrun_q, overrun_d;

  logic              wren;
  logic              boundary;
  logic              run_boundary;
  logic              drop;
  logic [SEG_W-1:0]  seg_inc;
  logic [SEG_W-1:0]  seg_s;

  assign wren     = sample_valid && (state_q != IDLE);
  // The write that fills the last slot of a segment completes that segment.
  assign boundary = wren && (&wptr_q[OFF_W-1:0]);
  assign seg_s    = wptr_q[ADDR_W-1 -: SEG_W];
  assign seg_inc  = seg_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wren ? wptr_q + 1'b1 : wptr_q;
    seg_cnt_d    = seg_cnt_q;
    in_flight_d  = in_flight_q;
    go_d         = 1'b0;
    ws_d         = ws_q;
    run_boundary = 1'b0;
    drop         = 1'b0;

    if (!enable) begin
      // Leaving for IDLE forgets any window in progress; overrun is kept.
      state_d     = IDLE;
      wptr_d      = '0;
      seg_cnt_d   = '0;
      in_flight_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (boundary) begin
            seg_cnt_d = seg_inc;
            // The boundary that makes the first window resident is also
            // the first scheduling boundary.
            if (seg_inc == SEG_W'(WINDOW_SEGS)) begin
              state_d      = RUN;
              run_boundary = 1'b1;
            end
          end
        end
        RUN:     run_boundary = boundary;
        default: state_d = IDLE;
      endcase

      if (run_boundary) begin
        // A done arriving with the boundary frees the hannifier in time.
        if (!in_flight_q || hann_done) begin
          go_d        = 1'b1;
          ws_d        = seg_s - SEG_W'(WINDOW_SEGS - 1);
          in_flight_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (hann_done) begin
        in_flight_d = 1'b0;
      end
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      seg_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      go_q        <= 1'b0;
      ws_q        <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      seg_cnt_q   <= seg_cnt_d;
      in_flight_q <= in_flight_d;
      go_q        <= go_d;
      ws_q        <= ws_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef WINDOW_SEQUENCER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (!enable) begin
      drop_cnt_d = '0;
    end else if (drop) begin
      if (overrun_clr) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (overrun_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign ring_buf_addr = wptr_q;
  assign ring_buf_wren = wren;
  assign window_start  = ws_q;
  assign go_out        = go_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_window_sequencer.sv
// tb/tb_window_sequencer.sv - directed table-driven bench for window_sequencer
module tb_window_sequencer;
  import sampler_pkg::*;

  localparam int AW = DEFAULT_ADDR_W;
  localparam int SW = DEFAULT_SEG_W;
  localparam int RING = 2 ** AW;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_valid;
  logic [AW-1:0] ring_buf_addr;
  logic          ring_buf_wren;
  logic [SW-1:0] window_start;
  logic          go_out;
  logic          hann_done;
  logic          overrun;
  logic          overrun_clr;
`ifdef WINDOW_SEQUENCER_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  window_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sample_valid  (sample_valid),
    .ring_buf_addr (ring_buf_addr),
    .ring_buf_wren (ring_buf_wren),
    .window_start  (window_start),
    .go_out        (go_out),
    .hann_done     (hann_done),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
`ifdef WINDOW_SEQUENCER_DROP_COUNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  typedef struct {
    bit restart;
    bit pre_clr;
    int addr;
    bit auto_done;
    bit done_edge;
    bit clr_edge;
    bit exp_go;
    int exp_ws;
    bit exp_ovr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int since_go = 1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (go_out) since_go = 0;
    else since_go++;
  endtask

  task automatic run_to(input int addr, input bit auto_done, output int stray);
    int n;
    n = 0;
    stray = 0;
    while (!(ring_buf_wren && ring_buf_addr == addr[AW-1:0]) && n < BUDGET) begin
      hann_done = auto_done && (since_go == 100);
      cyc();
      hann_done = 1'b0;
      if (go_out) stray++;
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL run_to_timeout: never reached address %0d within %0d cycles", addr, BUDGET);
    end
  endtask

  task automatic edge_check(input string tag, input int addr, input bit auto_done,
                            input bit done_edge, input bit clr_edge,
                            input bit exp_go, input int exp_ws, input bit exp_ovr);
    hann_done   = done_edge || (auto_done && (since_go == 100));
    overrun_clr = clr_edge;
    cyc();
    hann_done   = 1'b0;
    overrun_clr = 1'b0;
    chk($sformatf("%s_go", tag), go_out, exp_go);
    chk($sformatf("%s_ws", tag), window_start, exp_ws);
    chk($sformatf("%s_ovr", tag), overrun, exp_ovr);
    chk($sformatf("%s_addr", tag), ring_buf_addr, (addr + 1) % RING);
  endtask

  task automatic restart();
    enable    = 1'b0;
    hann_done = 1'b0;
    cyc();
    cyc();
    chk("restart_idle_wren", ring_buf_wren, 0);
    chk("restart_idle_addr", ring_buf_addr, 0);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("restart_ovr_clr", overrun, 0);
    enable = 1'b1;
    cyc();
    chk("restart_first_addr", ring_buf_addr, 0);
    chk("restart_first_wren", ring_buf_wren, 1);
    since_go = 1000;
  endtask

  vec_t vecs[14];

  initial begin
    int stray;

    //            rst pclr addr  auto done clr  go  ws  ovr
    vecs[0]  = '{1'b0, 1'b0, 4095, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5119, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 6143, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 7167, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8191, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1023, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2047, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3071, 1'b1, 1'b0, 1'b0, 1'b1, 7, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4095, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 5119, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 6143, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 4095, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 5119, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4095, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};

    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b1;
    hann_done    = 1'b0;
    overrun_clr  = 1'b0;
    cyc();
    cyc();
    chk("reset_addr", ring_buf_addr, 0);
    chk("reset_wren", ring_buf_wren, 0);
    chk("reset_go", go_out, 0);
    chk("reset_ws", window_start, 0);
    chk("reset_ovr", overrun, 0);
    reset = 1'b0;
    chk("post_reset_idle_wren", ring_buf_wren, 0);
    cyc();
    chk("first_write_addr", ring_buf_addr, 0);
    chk("first_write_wren", ring_buf_wren, 1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].restart) restart();
      if (vecs[i].pre_clr) begin
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk($sformatf("v%0d_pre_clr", i), overrun, 0);
      end
      run_to(vecs[i].addr, vecs[i].auto_done, stray);
      chk($sformatf("v%0d_stray_go", i), stray, 0);
      edge_check($sformatf("v%0d", i), vecs[i].addr, vecs[i].auto_done,
                 vecs[i].done_edge, vecs[i].clr_edge,
                 vecs[i].exp_go, vecs[i].exp_ws, vecs[i].exp_ovr);
    end

    // Mid-run disable at wptr=3000, then re-enable from scratch.
    run_to(3000, 1'b1, stray);
    enable = 1'b0;
    cyc();
    chk("dis_wren", ring_buf_wren, 0);
    chk("dis_addr", ring_buf_addr, 0);
    chk("dis_go", go_out, 0);
    cyc();
    chk("dis_wren_hold", ring_buf_wren, 0);
    enable = 1'b1;
    cyc();
    chk("reen_addr", ring_buf_addr, 0);
    chk("reen_wren", ring_buf_wren, 1);
    run_to(4095, 1'b0, stray);
    chk("reen_stray_go", stray, 0);
    edge_check("reen", 4095, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

`ifdef WINDOW_SEQUENCER_DROP_COUNT_EN
    restart();
    chk("drop_cnt_start", drop_count, 0);
    run_to(4095, 1'b0, stray);
    edge_check("dc0", 4095, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_to(5119, 1'b0, stray);
    edge_check("dc1", 5119, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_to(6143, 1'b0, stray);
    edge_check("dc2", 6143, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_to(7167, 1'b0, stray);
    edge_check("dc3", 7167, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("drop_cnt_three", drop_count, 3);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("drop_cnt_cleared", drop_count, 0);
    chk("drop_ovr_cleared", overrun, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
